clkdiv_multi: RTL and testbench



---
 rtl/clkdiv_pkg.sv | 15 +
 rtl/clkdiv_channel.sv | 86 ++++++++
 rtl/clkdiv_multi.sv | 105 ++++++++++
 tb/tb_clkdiv_multi.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared types for the multi-channel tick/blink generator.
//   mode_e : per-channel output pattern selector (OFF/ON/BLINK/ONESHOT)
//   MODE_W : width of the encoded mode field on the config port
package clkdiv_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_e;

endpackage

// File: rtl/clkdiv_channel.sv
// clkdiv_channel: one period/duty pattern generator advanced by the shared tick.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_tick         : advance phase by one step
//   i_apply        : load mode/period/duty and restart phase at 0 (wins over i_tick)
//   i_mode         : pattern to load on i_apply
//   i_period       : phase wraps after reaching this value (cycle = period+1 ticks)
//   i_duty         : output high while phase < duty (BLINK/ONESHOT)
//   o_out          : registered output, lags the channel state by one cycle
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int unsigned PER_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick,
  input  logic             i_apply,
  input  mode_e            i_mode,
  input  logic [PER_W-1:0] i_period,
  input  logic [PER_W-1:0] i_duty,
  output logic             o_out
);

  mode_e            r_mode;
  logic [PER_W-1:0] r_period;
  logic [PER_W-1:0] r_duty;
  logic [PER_W-1:0] r_phase;
  logic             r_out;

  mode_e            w_mode_d;
  logic [PER_W-1:0] w_phase_d;
  logic             w_out_d;

  always_comb begin
    w_mode_d  = r_mode;
    w_phase_d = r_phase;
    if (i_tick) begin
      if (r_phase >= r_period) begin
        w_phase_d = '0;
      end else begin
        w_phase_d = r_phase + PER_W'(1);
      end
      // A oneshot retires itself once its single cycle has completed.
      if ((r_mode == MODE_ONESHOT) && (r_phase == r_period)) begin
        w_mode_d  = MODE_OFF;
        w_phase_d = '0;
      end
    end
  end

  always_comb begin
    w_out_d = 1'b0;
    unique case (r_mode)
      MODE_OFF:     w_out_d = 1'b0;
      MODE_ON:      w_out_d = 1'b1;
      MODE_BLINK:   w_out_d = (r_phase < r_duty);
      MODE_ONESHOT: w_out_d = (r_phase < r_duty);
      default:      w_out_d = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode   <= MODE_OFF;
      r_period <= '0;
      r_duty   <= '0;
      r_phase  <= '0;
      r_out    <= 1'b0;
    end else begin
      if (i_apply) begin
        r_mode   <= i_mode;
        r_period <= i_period;
        r_duty   <= i_duty;
        r_phase  <= '0;
      end else begin
        r_mode  <= w_mode_d;
        r_phase <= w_phase_d;
      end
      r_out <= w_out_d;
    end
  end

  assign o_out = r_out;

endmodule

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: programmable prescaler tick plus CHANNELS pattern generators.
// Ports:
//   i_clk, i_rst_n     : system clock (global buffer net), async active-low reset
//   i_en               : global enable; low freezes prescaler, step and channel phases
//   i_pre_div          : prescaler reload; tick period = pre_div+1 clocks, sampled on reload
//   o_tick             : one-cycle pulse per prescaler wrap
//   o_step             : free-running tick counter
//   i_cfg_valid/o_cfg_ready : config handshake, one outstanding update
//   i_cfg_ch, i_cfg_mode, i_cfg_period, i_cfg_duty : config payload
//   o_ch_out           : registered channel outputs
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned DIV_W    = 24,
  parameter int unsigned PER_W    = 16,
  parameter int unsigned STEP_W   = 3,
  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic [DIV_W-1:0]    i_pre_div,
  output logic                o_tick,
  output logic [STEP_W-1:0]   o_step,
  input  logic                i_cfg_valid,
  output logic                o_cfg_ready,
  input  logic [CH_W-1:0]     i_cfg_ch,
  input  logic [MODE_W-1:0]   i_cfg_mode,
  input  logic [PER_W-1:0]    i_cfg_period,
  input  logic [PER_W-1:0]    i_cfg_duty,
  output logic [CHANNELS-1:0] o_ch_out
);

  logic [DIV_W-1:0]  r_pre_cnt;
  logic [STEP_W-1:0] r_step;
  logic              r_pending;
  logic [CH_W-1:0]   r_sh_ch;
  mode_e             r_sh_mode;
  logic [PER_W-1:0]  r_sh_period;
  logic [PER_W-1:0]  r_sh_duty;

  logic w_tick;
  logic w_accept;
  logic w_ch_ok;
  logic w_apply;

  // Reset gating keeps tick low while reset is asserted even if en is high.
  assign w_tick   = i_rst_n & i_en & (r_pre_cnt == '0);
  assign w_accept = i_cfg_valid & ~r_pending;
  assign w_ch_ok  = (32'(i_cfg_ch) < CHANNELS);
  // pending is only set the cycle after accept, so an accept on a tick cycle
  // naturally waits for the following tick. With en low there is no tick,
  // so the update goes in on the next clock instead.
  assign w_apply  = r_pending & (w_tick | ~i_en);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pre_cnt   <= '0;
      r_step      <= '0;
      r_pending   <= 1'b0;
      r_sh_ch     <= '0;
      r_sh_mode   <= MODE_OFF;
      r_sh_period <= '0;
      r_sh_duty   <= '0;
    end else begin
      if (i_en) begin
        r_pre_cnt <= (r_pre_cnt == '0) ? i_pre_div : r_pre_cnt - DIV_W'(1);
      end
      if (w_tick) begin
        r_step <= r_step + STEP_W'(1);
      end
      if (w_apply) begin
        r_pending <= 1'b0;
      end else if (w_accept && w_ch_ok) begin
        // Out-of-range channels are accepted but dropped here.
        r_pending   <= 1'b1;
        r_sh_ch     <= i_cfg_ch;
        r_sh_mode   <= mode_e'(i_cfg_mode);
        r_sh_period <= i_cfg_period;
        r_sh_duty   <= i_cfg_duty;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    clkdiv_channel #(
      .PER_W(PER_W)
    ) u_ch (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_tick  (w_tick),
      .i_apply (w_apply && (r_sh_ch == CH_W'(g))),
      .i_mode  (r_sh_mode),
      .i_period(r_sh_period),
      .i_duty  (r_sh_duty),
      .o_out   (o_ch_out[g])
    );
  end

  assign o_tick      = w_tick;
  assign o_step      = r_step;
  assign o_cfg_ready = ~r_pending;

endmodule

// File: tb/tb_clkdiv_multi.sv
// tb_clkdiv_multi: directed self-checking bench for clkdiv_multi.
// Inputs change and outputs are sampled just after the falling clock edge.
module tb_clkdiv_multi;

  localparam int unsigned CHANNELS = 3;
  localparam int unsigned DIV_W    = 24;
  localparam int unsigned PER_W    = 16;
  localparam int unsigned STEP_W   = 3;
  localparam int unsigned CH_W     = 2;

  logic                clk;
  logic                rst_n;
  logic                en;
  logic [DIV_W-1:0]    pre_div;
  logic                tick;
  logic [STEP_W-1:0]   step;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [CH_W-1:0]     cfg_ch;
  logic [1:0]          cfg_mode;
  logic [PER_W-1:0]    cfg_period;
  logic [PER_W-1:0]    cfg_duty;
  logic [CHANNELS-1:0] ch_out;

  int errors = 0;
  int checks = 0;

  clkdiv_multi #(
    .CHANNELS(CHANNELS),
    .DIV_W   (DIV_W),
    .PER_W   (PER_W),
    .STEP_W  (STEP_W)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_en        (en),
    .i_pre_div   (pre_div),
    .o_tick      (tick),
    .o_step      (step),
    .i_cfg_valid (cfg_valid),
    .o_cfg_ready (cfg_ready),
    .i_cfg_ch    (cfg_ch),
    .i_cfg_mode  (cfg_mode),
    .i_cfg_period(cfg_period),
    .i_cfg_duty  (cfg_duty),
    .o_ch_out    (ch_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ends right after a falling edge with reset released and en low.
  task automatic do_reset();
    rst_n      = 1'b0;
    en         = 1'b0;
    pre_div    = '0;
    cfg_valid  = 1'b0;
    cfg_ch     = '0;
    cfg_mode   = 2'd0;
    cfg_period = '0;
    cfg_duty   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents one request for a single cycle; the caller ensures ready is high.
  task automatic send_cfg(input logic [CH_W-1:0] ch, input logic [1:0] mode,
                          input logic [PER_W-1:0] period, input logic [PER_W-1:0] duty);
    cfg_valid  = 1'b1;
    cfg_ch     = ch;
    cfg_mode   = mode;
    cfg_period = period;
    cfg_duty   = duty;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    pre_div   = '0;
    @(negedge clk);
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%0h exp=0", tick); end
    checks++; if (step !== 3'd0) begin errors++; $display("FAIL reset_step got=%0h exp=0", step); end
    checks++; if (ch_out !== 3'b000) begin errors++; $display("FAIL reset_ch_out got=%0h exp=0", ch_out); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0h exp=1", cfg_ready); end
  endtask

  task automatic test_prescaler();
    logic             exp_tick;
    logic [STEP_W-1:0] exp_step;
    do_reset();
    pre_div = 24'd3;
    en      = 1'b1;
    #1;
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL first_tick got=%0h exp=1", tick); end
    // Ticks land on cycles 0,4,8,...; by cycle 4m, m ticks have been counted.
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      exp_tick = ((k % 4) == 0);
      checks++;
      if (tick !== exp_tick) begin
        errors++; $display("FAIL presc_tick k=%0d got=%0h exp=%0h", k, tick, exp_tick);
      end
      if ((k % 4) == 0) begin
        exp_step = STEP_W'(k / 4);
        checks++;
        if (step !== exp_step) begin
          errors++; $display("FAIL step_count k=%0d got=%0h exp=%0h", k, step, exp_step);
        end
      end
    end
  endtask

  task automatic test_blink_and_freeze();
    logic [4:0] pat;
    pat = 5'b00011;  // phases 0..4 with duty 2 -> 1,1,0,0,0
    do_reset();
    pre_div = '0;
    en      = 1'b1;
    send_cfg(2'd0, 2'd2, 16'd4, 16'd2);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL blink_ready_low got=%0h exp=0", cfg_ready); end
    @(negedge clk);
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL blink_ready_back got=%0h exp=1", cfg_ready); end
    checks++; if (ch_out[0] !== 1'b0) begin errors++; $display("FAIL blink_latency got=%0h exp=0", ch_out[0]); end
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      checks++;
      if (ch_out[0] !== pat[j % 5]) begin
        errors++; $display("FAIL blink_pat j=%0d got=%0h exp=%0h", j, ch_out[0], pat[j % 5]);
      end
    end
    en = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      checks++;
      if ({tick, ch_out[0]} !== 2'b01) begin
        errors++; $display("FAIL freeze j=%0d got tick=%0h out=%0h exp tick=0 out=1", j, tick, ch_out[0]);
      end
    end
    en = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      checks++;
      if (ch_out[0] !== pat[j]) begin
        errors++; $display("FAIL resume_pat j=%0d got=%0h exp=%0h", j, ch_out[0], pat[j]);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [9:0] pat;
    pat = 10'b00_0000_0011;
    do_reset();
    pre_div = '0;
    en      = 1'b1;
    send_cfg(2'd1, 2'd3, 16'd3, 16'd2);
    @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      checks++;
      if (ch_out[1] !== pat[j]) begin
        errors++; $display("FAIL oneshot j=%0d got=%0h exp=%0h", j, ch_out[1], pat[j]);
      end
    end
  endtask

  task automatic test_handshake();
    do_reset();
    pre_div    = 24'd9;
    en         = 1'b1;
    // Accept coincides with the first tick (cycle 0); apply must wait for cycle 10.
    cfg_valid  = 1'b1;
    cfg_ch     = 2'd0;
    cfg_mode   = 2'd1;
    cfg_period = '0;
    cfg_duty   = '0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 1) begin
        cfg_ch = 2'd2;  // second request held and stalled
      end
      if (k <= 10) begin
        checks++;
        if (cfg_ready !== 1'b0) begin errors++; $display("FAIL hs_ready_low k=%0d got=%0h exp=0", k, cfg_ready); end
      end
      if (k == 5) begin
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL hs_tick_mid got=%0h exp=0", tick); end
      end
      if (k == 10 || k == 20) begin
        checks++; if (tick !== 1'b1) begin errors++; $display("FAIL hs_tick k=%0d got=%0h exp=1", k, tick); end
      end
      if (k == 11) begin
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL hs_ready_ret got=%0h exp=1", cfg_ready); end
        checks++; if (ch_out[0] !== 1'b0) begin errors++; $display("FAIL hs_ch0_early got=%0h exp=0", ch_out[0]); end
      end
      if (k == 12) begin
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL hs_second_acc got=%0h exp=0", cfg_ready); end
        checks++; if (ch_out[0] !== 1'b1) begin errors++; $display("FAIL hs_ch0_on got=%0h exp=1", ch_out[0]); end
        cfg_valid = 1'b0;
      end
      if (k == 21) begin
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL hs_ready_ret2 got=%0h exp=1", cfg_ready); end
        checks++; if (ch_out[2] !== 1'b0) begin errors++; $display("FAIL hs_ch2_early got=%0h exp=0", ch_out[2]); end
      end
      if (k == 22) begin
        checks++; if (ch_out[2] !== 1'b1) begin errors++; $display("FAIL hs_ch2_on got=%0h exp=1", ch_out[2]); end
      end
    end
  endtask

  task automatic test_cfg_disabled();
    do_reset();
    pre_div = '0;
    send_cfg(2'd2, 2'd1, 16'd0, 16'd0);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL dis_pending got=%0h exp=0", cfg_ready); end
    @(negedge clk);
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL dis_applied got=%0h exp=1", cfg_ready); end
    @(negedge clk);
    checks++; if (ch_out !== 3'b100) begin errors++; $display("FAIL dis_ch_out got=%0h exp=4", ch_out); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL dis_tick got=%0h exp=0", tick); end
  endtask

  task automatic test_bad_channel();
    do_reset();
    pre_div = '0;
    en      = 1'b1;
    send_cfg(2'd3, 2'd1, 16'd0, 16'd0);
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL badch_ready got=%0h exp=1", cfg_ready); end
    repeat (3) @(negedge clk);
    checks++; if (ch_out !== 3'b000) begin errors++; $display("FAIL badch_out got=%0h exp=0", ch_out); end
  endtask

  task automatic test_duty_edges();
    do_reset();
    pre_div = '0;
    en      = 1'b1;
    send_cfg(2'd0, 2'd2, 16'd4, 16'd5);
    @(negedge clk);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      checks++;
      if (ch_out[0] !== 1'b1) begin errors++; $display("FAIL duty_over j=%0d got=%0h exp=1", j, ch_out[0]); end
    end
    send_cfg(2'd0, 2'd2, 16'd4, 16'd0);
    @(negedge clk);
    checks++; if (ch_out[0] !== 1'b1) begin errors++; $display("FAIL duty_switch_lat got=%0h exp=1", ch_out[0]); end
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      checks++;
      if (ch_out[0] !== 1'b0) begin errors++; $display("FAIL duty_zero j=%0d got=%0h exp=0", j, ch_out[0]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pre_div = '0;
    en      = 1'b1;
    send_cfg(2'd0, 2'd2, 16'd4, 16'd2);
    repeat (2) @(negedge clk);
    checks++; if (ch_out[0] !== 1'b1) begin errors++; $display("FAIL mid_pre_out got=%0h exp=1", ch_out[0]); end
    checks++; if (step !== 3'd3) begin errors++; $display("FAIL mid_pre_step got=%0h exp=3", step); end
    // Long reload parks the prescaler so the next request stays pending.
    pre_div = 24'd50;
    send_cfg(2'd1, 2'd1, 16'd0, 16'd0);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL mid_pending got=%0h exp=0", cfg_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ch_out !== 3'b000) begin errors++; $display("FAIL mid_async_out got=%0h exp=0", ch_out); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL mid_async_tick got=%0h exp=0", tick); end
    checks++; if (step !== 3'd0) begin errors++; $display("FAIL mid_async_step got=%0h exp=0", step); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_async_ready got=%0h exp=1", cfg_ready); end
    @(negedge clk);
    en    = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ch_out !== 3'b000) begin errors++; $display("FAIL mid_lost_cfg got=%0h exp=0", ch_out); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_after got=%0h exp=1", cfg_ready); end
  endtask

  initial begin
    test_reset();
    test_prescaler();
    test_blink_and_freeze();
    test_oneshot();
    test_handshake();
    test_cfg_disabled();
    test_bad_channel();
    test_duty_edges();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
